// File: rtl/ravenoc_pkg.sv
// ravenoc_pkg -- shared types for the router input stage.
//   e_port_t      : router port directions, also the index of the output request array
//   NumVirtChn    : virtual channels per link; VcWidth bits select one
//   HighPriority  : which end of the VC index range wins arbitration
//   e_flit_t      : flit kind carried in the two MSBs of every flit
//   s_head_flit_t : head flit layout (type, XY destination, packet size, payload)
//   s_flit_req_t  : link request (valid, vc_id, fdata)
//   s_flit_resp_t : link response (per-VC ready)
//   xy_route()    : dimension-ordered (X then Y) route for a destination
package ravenoc_pkg;

  typedef enum logic [2:0] {
    LOCAL_PORT = 3'd0,
    NORTH_PORT = 3'd1,
    SOUTH_PORT = 3'd2,
    WEST_PORT  = 3'd3,
    EAST_PORT  = 3'd4
  } e_port_t;

  localparam int unsigned NumPorts   = 5;
  localparam int unsigned NumVirtChn = 2;
  localparam int unsigned VcWidth    = 1;

  // ZeroLowPrior: VC0 is the lowest priority, so the highest index wins.
  typedef enum logic {
    ZeroLowPrior,
    ZeroHighPrior
  } e_prior_t;

  localparam e_prior_t HighPriority = ZeroLowPrior;

  localparam int unsigned FlitWidth  = 32;
  localparam int unsigned XWidth     = 2;
  localparam int unsigned YWidth     = 2;
  localparam int unsigned PktSzWidth = 8;

  // Bit positions of the head flit fields inside fdata.
  localparam int unsigned FtypeLsb = FlitWidth - 2;
  localparam int unsigned XLsb     = FtypeLsb - XWidth;
  localparam int unsigned YLsb     = XLsb - YWidth;
  localparam int unsigned PktLsb   = YLsb - PktSzWidth;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'd0,
    BODY_FLIT = 2'd1,
    TAIL_FLIT = 2'd2
  } e_flit_t;

  typedef struct packed {
    e_flit_t                 ftype;
    logic [XWidth-1:0]       x_dest;
    logic [YWidth-1:0]       y_dest;
    logic [PktSzWidth-1:0]   pkt_size;
    logic [PktLsb-1:0]       payload;
  } s_head_flit_t;

  typedef struct packed {
    logic                 valid;
    logic [VcWidth-1:0]   vc_id;
    logic [FlitWidth-1:0] fdata;
  } s_flit_req_t;

  typedef struct packed {
    logic [NumVirtChn-1:0] ready;
  } s_flit_resp_t;

  function automatic e_port_t xy_route(input logic [XWidth-1:0] x_dest,
                                       input logic [YWidth-1:0] y_dest,
                                       input int unsigned       router_x,
                                       input int unsigned       router_y);
    int unsigned xd;
    int unsigned yd;
    xd = 32'(x_dest);
    yd = 32'(y_dest);
    if (xd > router_x) return EAST_PORT;
    if (xd < router_x) return WEST_PORT;
    if (yd > router_y) return SOUTH_PORT;
    if (yd < router_y) return NORTH_PORT;
    return LOCAL_PORT;
  endfunction

endpackage

// File: rtl/vc_flit_fifo.sv
// vc_flit_fifo -- synchronous single-clock FIFO holding the flits of one VC.
//   clk      : clock
//   arst     : synchronous active-low reset, empties the FIFO
//   i_wr_en  : write request (ignored while full)
//   i_wdata  : write data
//   i_rd_en  : read request (ignored while empty)
//   o_rdata  : head entry, valid whenever o_empty is 0
//   o_full   : no free slot
//   o_empty  : no stored entry
module vc_flit_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             i_wr_en,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_rd_en,
  output logic [Width-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam logic [PtrWidth:0] PtrOne = (PtrWidth + 1)'(1);

  logic [Width-1:0]  r_mem [Depth];
  // One extra pointer bit tells full from empty when the indices match.
  logic [PtrWidth:0] r_wptr;
  logic [PtrWidth:0] r_rptr;
  logic              w_wr;
  logic              w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PtrWidth] != r_rptr[PtrWidth]) &&
                   (r_wptr[PtrWidth-1:0] == r_rptr[PtrWidth-1:0]);
  assign w_wr    = i_wr_en && !o_full;
  assign w_rd    = i_rd_en && !o_empty;
  assign o_rdata = r_mem[r_rptr[PtrWidth-1:0]];

  always_ff @(posedge clk) begin
    if (!arst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PtrOne;
      if (w_rd) r_rptr <= r_rptr + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[PtrWidth-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/vc_input_stage.sv
// vc_input_stage -- router input port: per-VC buffering, XY routing and VC arbitration.
//   clk         : clock
//   arst        : synchronous active-low reset
//   fin_req_i   : incoming link flit (valid, vc_id, fdata)
//   fin_resp_o  : per-VC buffer space returned upstream (ready = not full)
//   fout_req_o  : one request per output port, indexed by e_port_t; only the routed one is driven
//   fout_resp_i : per-VC ready returned by each output
//   route_err_o : sticky flag, set when a packet would leave through the port it came in on
// Build option: define VC_INPUT_BYPASS_EN to forward a flit straight to its output when its
// VC FIFO is empty, the VC wins arbitration and the output is ready.
module vc_input_stage
  import ravenoc_pkg::*;
#(
  parameter int unsigned RouterX     = 0,
  parameter int unsigned RouterY     = 0,
  parameter e_port_t     InPort      = LOCAL_PORT,
  parameter int unsigned BufferDepth = 4
) (
  input  logic                    clk,
  input  logic                    arst,
  input  s_flit_req_t             fin_req_i,
  output s_flit_resp_t            fin_resp_o,
  output s_flit_req_t [4:0]       fout_req_o,
  input  s_flit_resp_t [4:0]      fout_resp_i,
  output logic                    route_err_o
);

  logic [NumVirtChn-1:0] w_full;
  logic [NumVirtChn-1:0] w_empty;
  logic [NumVirtChn-1:0] w_wr;
  logic [NumVirtChn-1:0] w_rd;
  logic [FlitWidth-1:0]  w_rdata [NumVirtChn];

  // Per-VC packet state: an open packet (lock) and the route its body/tail follow.
  logic [NumVirtChn-1:0] r_lock;
  e_port_t               r_route [NumVirtChn];
  logic                  r_err;

  logic [NumVirtChn-1:0] w_cand;
  logic                  w_any;
  logic [VcWidth-1:0]    w_sel;
  logic [FlitWidth-1:0]  w_flit;
  e_flit_t               w_ftype;
  logic                  w_is_head;
  logic                  w_is_tail;
  logic                  w_has_body;
  e_port_t               w_xy;
  e_port_t               w_route;
  logic                  w_uturn;
  logic                  w_discard;
  logic                  w_deq;
`ifdef VC_INPUT_BYPASS_EN
  logic                  w_byp;
`endif

  for (genvar v = 0; v < NumVirtChn; v++) begin : g_vc
    vc_flit_fifo #(
      .Depth (BufferDepth),
      .Width (FlitWidth)
    ) u_fifo (
      .clk     (clk),
      .arst    (arst),
      .i_wr_en (w_wr[v]),
      .i_wdata (fin_req_i.fdata),
      .i_rd_en (w_rd[v]),
      .o_rdata (w_rdata[v]),
      .o_full  (w_full[v]),
      .o_empty (w_empty[v])
    );
  end

  assign fin_resp_o.ready = ~w_full;
  assign route_err_o      = r_err;

  // A VC competes when it holds a flit (or, with bypass, is receiving one into an empty FIFO).
  always_comb begin
    w_cand = ~w_empty;
`ifdef VC_INPUT_BYPASS_EN
    for (int v = 0; v < NumVirtChn; v++) begin
      if (fin_req_i.valid && (fin_req_i.vc_id == VcWidth'(v))) w_cand[v] = 1'b1;
    end
`endif
  end

  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    if (HighPriority == ZeroLowPrior) begin
      for (int v = 0; v < NumVirtChn; v++) begin
        if (w_cand[v]) begin
          w_any = 1'b1;
          w_sel = VcWidth'(v);
        end
      end
    end else begin
      for (int v = NumVirtChn - 1; v >= 0; v--) begin
        if (w_cand[v]) begin
          w_any = 1'b1;
          w_sel = VcWidth'(v);
        end
      end
    end
  end

  always_comb begin
    w_flit = w_rdata[w_sel];
`ifdef VC_INPUT_BYPASS_EN
    w_byp = 1'b0;
    if (w_empty[w_sel]) begin
      w_byp  = 1'b1;
      w_flit = fin_req_i.fdata;
    end
`endif
  end

  assign w_ftype    = e_flit_t'(w_flit[FtypeLsb +: 2]);
  assign w_is_head  = (w_ftype == HEAD_FLIT);
  assign w_is_tail  = (w_ftype == TAIL_FLIT);
  assign w_has_body = (w_flit[PktLsb +: PktSzWidth] != '0);
  assign w_xy       = xy_route(w_flit[XLsb +: XWidth], w_flit[YLsb +: YWidth], RouterX, RouterY);
  assign w_route    = w_is_head ? w_xy : r_route[w_sel];
  assign w_uturn    = w_is_head && (w_xy == InPort);
  // Body/tail flits travel only while their VC holds an open route; after a dropped U-turn
  // head no route is opened, so the rest of that packet is discarded up to its tail.
  assign w_discard  = w_uturn || (!w_is_head && !r_lock[w_sel]);

  always_comb begin
    fout_req_o = '0;
    w_deq      = 1'b0;
    if (w_any) begin
      if (w_discard) begin
        w_deq = 1'b1;
      end else begin
        fout_req_o[w_route].valid = 1'b1;
        fout_req_o[w_route].vc_id = w_sel;
        fout_req_o[w_route].fdata = w_flit;
        w_deq = fout_resp_i[w_route].ready[w_sel];
      end
    end
  end

  always_comb begin
    w_wr = '0;
    w_rd = '0;
    for (int v = 0; v < NumVirtChn; v++) begin
      w_rd[v] = w_deq && (w_sel == VcWidth'(v));
      w_wr[v] = fin_req_i.valid && (fin_req_i.vc_id == VcWidth'(v)) && !w_full[v];
`ifdef VC_INPUT_BYPASS_EN
      // A flit forwarded this cycle must not also be buffered.
      if (w_byp && w_deq && (w_sel == VcWidth'(v))) w_wr[v] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      r_lock <= '0;
      r_err  <= 1'b0;
      for (int v = 0; v < NumVirtChn; v++) r_route[v] <= LOCAL_PORT;
    end else if (w_deq) begin
      if (w_is_head) begin
        if (w_uturn) begin
          r_err <= 1'b1;
        end else if (w_has_body) begin
          r_route[w_sel] <= w_xy;
          r_lock[w_sel]  <= 1'b1;
        end
      end else if (w_is_tail) begin
        r_lock[w_sel] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vc_input_stage.sv
module tb_vc_input_stage;
  import ravenoc_pkg::*;

  localparam int unsigned RX = 1;
  localparam int unsigned RY = 1;
  localparam e_port_t     InPortTb = WEST_PORT;

  typedef struct packed {
    e_port_t     port;
    logic [31:0] data;
  } exp_t;

  logic                clk;
  logic                arst;
  s_flit_req_t         fin_req_i;
  s_flit_resp_t        fin_resp_o;
  s_flit_req_t  [4:0]  fout_req_o;
  s_flit_resp_t [4:0]  fout_resp_i;
  logic                route_err_o;

  int n_vec;
  int n_err;
  int rdy_mode;  // 0: all outputs ready, 1: random ready, 2: held by the main sequence
  logic err_exp;

  exp_t        q0[$];
  exp_t        q1[$];
  int          acc_log[$];
  logic [31:0] pkt_q[$];
  logic [31:0] s0[$];
  logic [31:0] s1[$];
  s_flit_req_t [4:0] e_arr;

  vc_input_stage #(
    .RouterX     (RX),
    .RouterY     (RY),
    .InPort      (InPortTb),
    .BufferDepth (4)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .fin_req_i   (fin_req_i),
    .fin_resp_o  (fin_resp_o),
    .fout_req_o  (fout_req_o),
    .fout_resp_i (fout_resp_i),
    .route_err_o (route_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference route: compare destination against this router, X dimension first.
  function automatic e_port_t ref_route(input int x, input int y);
    int dx;
    int dy;
    dx = x - int'(RX);
    dy = y - int'(RY);
    if (dx > 0) return EAST_PORT;
    if (dx < 0) return WEST_PORT;
    if (dy > 0) return SOUTH_PORT;
    if (dy < 0) return NORTH_PORT;
    return LOCAL_PORT;
  endfunction

  function automatic logic [31:0] mk_head(input int x, input int y, input int sz);
    s_head_flit_t h;
    h.ftype    = HEAD_FLIT;
    h.x_dest   = 2'(x);
    h.y_dest   = 2'(y);
    h.pkt_size = 8'(sz);
    h.payload  = 18'($urandom);
    return h;
  endfunction

  function automatic logic [31:0] mk_flit(input e_flit_t t);
    logic [29:0] d;
    d = 30'($urandom);
    return {t, d};
  endfunction

  task automatic exp_push(input int v, input e_port_t p, input logic [31:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    if (v == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Builds one packet into pkt_q and records what must come out of the stage.
  task automatic build_pkt(input int v, input int x, input int y, input int sz);
    e_port_t r;
    r = ref_route(x, y);
    pkt_q.delete();
    pkt_q.push_back(mk_head(x, y, sz));
    for (int i = 1; i <= sz; i++) pkt_q.push_back(mk_flit((i == sz) ? TAIL_FLIT : BODY_FLIT));
    if (r == InPortTb) err_exp = 1'b1;
    else foreach (pkt_q[i]) exp_push(v, r, pkt_q[i]);
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the flit.
  task automatic send_flit(input int v, input logic [31:0] d);
    int n;
    n = 0;
    fin_req_i.valid = 1'b1;
    fin_req_i.vc_id = 1'(v);
    fin_req_i.fdata = d;
    while (!fin_resp_o.ready[v] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!fin_resp_o.ready[v]) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: vc %0d ready stayed 0, required 1", v);
    end
    @(posedge clk); #1;
    fin_req_i.valid = 1'b0;
  endtask

  task automatic send_pkt(input int v);
    foreach (pkt_q[i]) send_flit(v, pkt_q[i]);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin @(posedge clk); #1; end
    n_vec++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL drain_%s: %0d/%0d flits still pending, required 0", tag, q0.size(), q1.size());
    end
  endtask

  task automatic monitor_cycle();
    int nv;
    int vp;
    int v;
    exp_t e;
    s_flit_req_t [4:0] others;
    nv = 0;
    vp = 0;
    for (int p = 0; p < 5; p++) begin
      if (fout_req_o[p].valid) begin
        nv++;
        vp = p;
      end
    end
    if (nv == 0) begin
      check("idle_outputs", fout_req_o, '0);
      return;
    end
    if (nv > 1) begin
      n_vec++;
      n_err++;
      $display("FAIL one_hot_out: %0d outputs valid, required 1", nv);
      return;
    end
    others = fout_req_o;
    others[vp] = '0;
    check("unused_outputs", others, '0);
    v = int'(fout_req_o[vp].vc_id);
    if ((v == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_flit: port %0d vc %0d data %0h, required no flit", vp, v,
               fout_req_o[vp].fdata);
      return;
    end
    e = (v == 0) ? q0[0] : q1[0];
    check("out_port", 256'(vp), 256'(int'(e.port)));
    check("out_data", fout_req_o[vp].fdata, e.data);
    if (fout_resp_i[vp].ready[v]) begin
      if (v == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
      acc_log.push_back(v);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (arst) monitor_cycle();
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) begin
        for (int p = 0; p < 5; p++) fout_resp_i[p].ready = '1;
      end else if (rdy_mode == 1) begin
        for (int p = 0; p < 5; p++) fout_resp_i[p].ready = 2'($urandom);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    int v;
    logic [31:0] f;
    n_vec     = 0;
    n_err     = 0;
    rdy_mode  = 0;
    err_exp   = 1'b0;
    arst      = 1'b0;
    fin_req_i = '0;
    fout_resp_i = '0;
    repeat (3) @(posedge clk);
    #1;
    arst = 1'b1;
    check("rst_ready", fin_resp_o.ready, 2'b11);
    check("rst_fout", fout_req_o, '0);
    check("rst_err", route_err_o, 1'b0);

    // Single-flit head to (3,1): EAST one cycle after the write.
    build_pkt(0, 3, 1, 0);
    send_flit(0, pkt_q[0]);
    e_arr = '0;
    e_arr[EAST_PORT].valid = 1'b1;
    e_arr[EAST_PORT].vc_id = 1'b0;
    e_arr[EAST_PORT].fdata = pkt_q[0];
    check("east_latency", fout_req_o, e_arr);
    wait_drain("single");

    // Four-flit packet to (1,0): every flit on NORTH, in order.
    build_pkt(0, 1, 0, 3);
    send_pkt(0);
    wait_drain("north_pkt");

    // Fill VC1 with outputs stalled, then release exactly one flit.
    rdy_mode = 2;
    fout_resp_i = '0;
    build_pkt(1, 2, 1, 3);
    send_pkt(1);
    check("full_ready1", fin_resp_o.ready[1], 1'b0);
    check("full_ready0", fin_resp_o.ready[0], 1'b1);
    // Illegal write while full, same cycle as the dequeue: must vanish.
    fin_req_i.valid = 1'b1;
    fin_req_i.vc_id = 1'b1;
    fin_req_i.fdata = mk_head(1, 1, 0);
    fout_resp_i[EAST_PORT].ready[1] = 1'b1;
    @(posedge clk); #1;
    fin_req_i.valid = 1'b0;
    fout_resp_i = '0;
    check("deq_ready1", fin_resp_o.ready[1], 1'b1);
    rdy_mode = 0;
    for (int p = 0; p < 5; p++) fout_resp_i[p].ready = '1;
    wait_drain("full");

    // Preemption: VC0 mid-packet, VC1 head arrives and wins, VC0 resumes on NORTH.
    acc_log.delete();
    rdy_mode = 2;
    fout_resp_i = '0;
    build_pkt(0, 1, 0, 3);
    s0 = pkt_q;
    send_flit(0, s0[0]);
    send_flit(0, s0[1]);
    for (int p = 0; p < 5; p++) fout_resp_i[p].ready = '1;
    @(posedge clk); #1;
    fout_resp_i = '0;
    build_pkt(1, 1, 2, 1);
    send_pkt(1);
    send_flit(0, s0[2]);
    send_flit(0, s0[3]);
    s0.delete();
    rdy_mode = 0;
    for (int p = 0; p < 5; p++) fout_resp_i[p].ready = '1;
    wait_drain("preempt");
    check("preempt_count", acc_log.size(), 6);
    for (int i = 0; i < acc_log.size() && i < 6; i++) begin
      check($sformatf("preempt_order%0d", i), acc_log[i], (i == 1 || i == 2) ? 1 : 0);
    end

    // Randomised traffic on both VCs with random output back-pressure.
    err_exp = 1'b0;
    for (int k = 0; k < 30; k++) begin
      for (int vv = 0; vv < 2; vv++) begin
        build_pkt(vv, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        foreach (pkt_q[i]) begin
          if (vv == 0) s0.push_back(pkt_q[i]);
          else s1.push_back(pkt_q[i]);
        end
      end
    end
    rdy_mode = 1;
    while (s0.size() != 0 || s1.size() != 0) begin
      if (s0.size() == 0) v = 1;
      else if (s1.size() == 0) v = 0;
      else v = $urandom_range(0, 1);
      f = (v == 0) ? s0.pop_front() : s1.pop_front();
      send_flit(v, f);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    wait_drain("random");
    check("random_err", route_err_o, err_exp);

    // Reset in the middle of a stalled packet.
    rdy_mode = 2;
    fout_resp_i = '0;
    build_pkt(0, 3, 3, 3);
    send_flit(0, pkt_q[0]);
    send_flit(0, pkt_q[1]);
    arst = 1'b0;
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    arst = 1'b1;
    check("midrst_ready", fin_resp_o.ready, 2'b11);
    check("midrst_fout", fout_req_o, '0);
    check("midrst_err", route_err_o, 1'b0);
    rdy_mode = 0;
    for (int p = 0; p < 5; p++) fout_resp_i[p].ready = '1;
    repeat (10) begin @(posedge clk); #1; end

    // U-turn toward WEST is dropped whole; the next packet on VC0 still flows.
    build_pkt(0, 0, 1, 2);
    send_pkt(0);
    build_pkt(0, 1, 1, 1);
    send_pkt(0);
    wait_drain("uturn");
    check("uturn_err", route_err_o, 1'b1);
    check("uturn_ready", fin_resp_o.ready, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
